// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store memory access controller.
//   - access size encodings (size_i)
//   - controller FSM state encoding
//   - misalignment predicate used when a request is accepted
package mem_access_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Reserved size is treated as misaligned so it is rejected without touching memory.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addr_lo[0];
         SZ_WORD: mis = (addr_lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the pipeline request/response signals and the data-memory port.
//   slave  : the controller (receives requests, drives the memory strobes)
//   master : the pipeline + data memory side (drives requests, returns read data)
// Pipeline side : req_i, we_i, size_i, sign_ext_i, addr_i, wdata_i -> stall_o, done_o,
//                 misaligned_o, rdata_o
// Memory side   : mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o <- mem_rdata_i
interface mem_access_ctrl_if;

   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        sign_ext_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        stall_o;
   logic        done_o;
   logic        misaligned_o;
   logic [31:0] rdata_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  req_i, we_i, size_i, sign_ext_i, addr_i, wdata_i, mem_rdata_i,
      output stall_o, done_o, misaligned_o, rdata_o,
             mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output req_i, we_i, size_i, sign_ext_i, addr_i, wdata_i, mem_rdata_i,
      input  stall_o, done_o, misaligned_o, rdata_o,
             mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling for sub-word accesses (little-endian).
//   word_i     : word read from memory
//   wdata_i    : right-aligned store data
//   addr_lo_i  : byte offset within the word
//   size_i     : access size
//   sign_ext_i : replicate lane MSB on loads
//   load_o     : extracted and extended load value
//   merged_o   : word_i with the addressed lane replaced by store data
import mem_access_ctrl_pkg::*;

module mem_lane_align (
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
      half_lane = word_i[{addr_lo_i[1], 4'b0000} +: 16];

      case (size_i)
         SZ_BYTE: load_o = {{24{sign_ext_i & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_o = {{16{sign_ext_i & half_lane[15]}}, half_lane};
         default: load_o = word_i;
      endcase

      merged_o = word_i;
      case (size_i)
         SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]      = wdata_i[7:0];
         SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         default: merged_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a pipeline and a word-indexed, registered-read data memory.
// Handles byte/half/word loads with optional sign extension, word stores, and sub-word
// stores via read-modify-write. Misaligned or reserved-size requests complete in one
// cycle flagged by misaligned_o without any memory traffic.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : mem_access_ctrl_if.slave (pipeline request/response + data-memory port)
//
// state | meaning
// IDLE  | waiting for req_i; captures the request
// READ  | mem_read_o asserted for the addressed word
// WAIT  | memory data valid; load lane registered or store word merged
// WRITE | mem_write_o asserted with the final word
// DONE  | done_o pulse, misaligned_o qualifies it
import mem_access_ctrl_pkg::*;

module mem_access_ctrl (
   input  logic              clk_i,
   input  logic              rst_i,
   mem_access_ctrl_if.slave  bus
);

   state_t      state_q, state_d;
   logic [31:0] addr_q,  addr_d;
   logic [1:0]  size_q,  size_d;
   logic        we_q,    we_d;
   logic        sext_q,  sext_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mis_q,   mis_d;
   logic [31:0] wword_q, wword_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] load_val;
   logic [31:0] merged_val;

   mem_lane_align u_lane (
      .word_i     (bus.mem_rdata_i),
      .wdata_i    (wdata_q),
      .addr_lo_i  (addr_q[1:0]),
      .size_i     (size_q),
      .sign_ext_i (sext_q),
      .load_o     (load_val),
      .merged_o   (merged_val)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         wdata_q <= '0;
         mis_q   <= 1'b0;
         wword_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         we_q    <= we_d;
         sext_q  <= sext_d;
         wdata_q <= wdata_d;
         mis_q   <= mis_d;
         wword_q <= wword_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      we_d    = we_q;
      sext_d  = sext_q;
      wdata_d = wdata_q;
      mis_d   = mis_q;
      wword_d = wword_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_i) begin
               addr_d  = bus.addr_i;
               size_d  = bus.size_i;
               we_d    = bus.we_i;
               sext_d  = bus.sign_ext_i;
               wdata_d = bus.wdata_i;
               mis_d   = is_misaligned(bus.size_i, bus.addr_i[1:0]);
               if (is_misaligned(bus.size_i, bus.addr_i[1:0])) begin
                  state_d = ST_DONE;
               end else if (bus.we_i && (bus.size_i == SZ_WORD)) begin
                  // Full-word store needs no read: the write word is the store data.
                  wword_d = bus.wdata_i;
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: state_d = ST_WAIT;
         ST_WAIT: begin
            if (we_q) begin
               wword_d = merged_val;
               state_d = ST_WRITE;
            end else begin
               rdata_d = load_val;
               state_d = ST_DONE;
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Moore outputs: strobes and address decode from state only, so an async reset
   // removes them before the next edge.
   assign bus.mem_read_o   = (state_q == ST_READ);
   assign bus.mem_write_o  = (state_q == ST_WRITE);
   assign bus.mem_addr_o   = ((state_q == ST_READ) || (state_q == ST_WRITE)) ?
                             {2'b00, addr_q[31:2]} : 32'd0;
   assign bus.mem_wdata_o  = (state_q == ST_WRITE) ? wword_q : 32'd0;
   assign bus.done_o       = (state_q == ST_DONE);
   assign bus.misaligned_o = (state_q == ST_DONE) && mis_q;
   assign bus.rdata_o      = rdata_q;
   assign bus.stall_o      = ((state_q == ST_IDLE) && bus.req_i) ||
                             (state_q == ST_READ) || (state_q == ST_WAIT) ||
                             (state_q == ST_WRITE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios followed by random
// accesses, compared against a word-array reference model of memory and load results.
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load_mem = 1'b1;

   always #5 clk = ~clk;

   mem_access_ctrl_if bus ();

   mem_access_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   logic [31:0] mem      [16];
   logic [31:0] init_mem [16];
   logic [31:0] ref_mem  [16];
   logic [31:0] exp_rdata;

   int total  = 0;
   int passed = 0;

   // Data memory: registered read data, synchronous write.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
      end else begin
         if (bus.mem_read_o)  bus.mem_rdata_i <= mem[bus.mem_addr_o[3:0]];
         if (bus.mem_write_o) mem[bus.mem_addr_o[3:0]] <= bus.mem_wdata_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One complete access: model the expected outcome, drive, observe, compare, update model.
   task automatic access(input string tag, input logic we, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
      int unsigned idx, sh, exp_done, exp_rd_n, exp_wr_n, exp_wr_cyc;
      logic [31:0] word, lane, exp_wdata, exp_load;
      bit mis;
      int cyc_done, rd_n, rd_cyc, wr_n, wr_cyc;
      logic [31:0] rd_addr, wr_addr, wr_data;
      bit got_done, stall_ok, mis_obs, mis_ok;

      idx  = a[5:2];
      word = ref_mem[idx];
      sh   = a[1:0] * 8;
      mis  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0);
      exp_load  = word;
      exp_wdata = wd;
      if (sz == 2'd0) begin
         lane = (word >> sh) & 32'hFF;
         exp_load  = (sx && lane[7]) ? (lane | 32'hFFFF_FF00) : lane;
         exp_wdata = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else if (sz == 2'd1) begin
         lane = (word >> sh) & 32'hFFFF;
         exp_load  = (sx && lane[15]) ? (lane | 32'hFFFF_0000) : lane;
         exp_wdata = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      if (mis) begin
         exp_done = 1; exp_rd_n = 0; exp_wr_n = 0; exp_wr_cyc = 0;
      end else if (!we) begin
         exp_done = 3; exp_rd_n = 1; exp_wr_n = 0; exp_wr_cyc = 0;
      end else if (sz == 2'd2) begin
         exp_done = 2; exp_rd_n = 0; exp_wr_n = 1; exp_wr_cyc = 1;
      end else begin
         exp_done = 4; exp_rd_n = 1; exp_wr_n = 1; exp_wr_cyc = 3;
      end

      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = we; bus.size_i = sz; bus.sign_ext_i = sx;
      bus.addr_i = a; bus.wdata_i = wd;
      #1;
      stall_ok = (bus.stall_o === 1'b1);
      mis_ok = (bus.misaligned_o === 1'b0) && (bus.done_o === 1'b0);
      rd_n = 0; wr_n = 0; rd_cyc = 0; wr_cyc = 0; cyc_done = 0;
      rd_addr = 0; wr_addr = 0; wr_data = 0; got_done = 0; mis_obs = 0;
      if (bus.mem_read_o || bus.mem_write_o) stall_ok = 0;
      for (int c = 1; c <= 8 && !got_done; c++) begin
         @(posedge clk);
         @(negedge clk);
         bus.req_i = 1'b0;
         if (bus.mem_read_o === 1'b1) begin
            rd_n++; rd_cyc = c; rd_addr = bus.mem_addr_o;
         end
         if (bus.mem_write_o === 1'b1) begin
            wr_n++; wr_cyc = c; wr_addr = bus.mem_addr_o; wr_data = bus.mem_wdata_o;
         end
         if (bus.done_o === 1'b1) begin
            got_done = 1; cyc_done = c; mis_obs = bus.misaligned_o;
            if (bus.stall_o !== 1'b0) stall_ok = 0;
         end else begin
            if (bus.stall_o !== 1'b1) stall_ok = 0;
            if (bus.misaligned_o !== 1'b0) mis_ok = 0;
         end
      end

      chk({tag, " done_seen"}, {31'd0, got_done}, 32'd1);
      chk({tag, " done_cycle"}, cyc_done, exp_done);
      chk({tag, " misaligned"}, {31'd0, mis_obs}, {31'd0, mis});
      chk({tag, " stall"}, {31'd0, stall_ok}, 32'd1);
      chk({tag, " mis_outside_done"}, {31'd0, mis_ok}, 32'd1);
      chk({tag, " reads"}, rd_n, exp_rd_n);
      chk({tag, " writes"}, wr_n, exp_wr_n);
      if (exp_rd_n != 0) begin
         chk({tag, " read_cycle"}, rd_cyc, 1);
         chk({tag, " read_addr"}, rd_addr, {2'b00, a[31:2]});
      end
      if (exp_wr_n != 0) begin
         chk({tag, " write_cycle"}, wr_cyc, exp_wr_cyc);
         chk({tag, " write_addr"}, wr_addr, {2'b00, a[31:2]});
         chk({tag, " write_data"}, wr_data, exp_wdata);
      end

      if (!mis && !we) exp_rdata = exp_load;
      if (!mis && we)  ref_mem[idx] = exp_wdata;
      chk({tag, " rdata"}, bus.rdata_o, exp_rdata);
      chk({tag, " mem_word"}, mem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [31:0] held;
      bus.req_i = 0; bus.we_i = 0; bus.size_i = 0; bus.sign_ext_i = 0;
      bus.addr_i = 0; bus.wdata_i = 0; bus.mem_rdata_i = 0;
      for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
      init_mem[3] = 32'h8899_AABB;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];
      exp_rdata = 32'd0;

      #2;
      chk("rst stall", {31'd0, bus.stall_o}, 32'd0);
      chk("rst done", {31'd0, bus.done_o}, 32'd0);
      chk("rst rdata", bus.rdata_o, 32'd0);
      chk("rst strobes", {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);
      chk("rst mem_addr", bus.mem_addr_o, 32'd0);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      load_mem = 1'b0;
      rst = 1'b0;

      access("lw_0C",  1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
      access("lb_0D",  1'b0, 2'd0, 1'b1, 32'h0D, 32'h0);
      access("lbu_0D", 1'b0, 2'd0, 1'b0, 32'h0D, 32'h0);
      access("lh_0E",  1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
      access("sb_0E",  1'b1, 2'd0, 1'b0, 32'h0E, 32'h1234_5677);
      chk("sb_0E word", mem[3], 32'h8877_AABB);
      access("sh_0F",  1'b1, 2'd1, 1'b0, 32'h0F, 32'h0000_5555);
      access("sw_10",  1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
      access("lw_10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      chk("lw_10 value", bus.rdata_o, 32'hDEAD_BEEF);
      access("lw_rsvd", 1'b0, 2'd3, 1'b0, 32'h08, 32'h0);

      // Reset while the WRITE strobe is up: the store must never reach memory.
      held = mem[8];
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'd2; bus.addr_i = 32'h20;
      bus.wdata_i = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      bus.req_i = 1'b0;
      chk("rstw write_before", {31'd0, bus.mem_write_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstw write_drop", {31'd0, bus.mem_write_o}, 32'd0);
      chk("rstw stall", {31'd0, bus.stall_o}, 32'd0);
      chk("rstw wdata", bus.mem_wdata_o, 32'd0);
      chk("rstw rdata", bus.rdata_o, 32'd0);
      exp_rdata = 32'd0;
      @(posedge clk);
      @(negedge clk);
      chk("rstw mem_word", mem[8], held);
      rst = 1'b0;
      access("after_rst_lw", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);

      for (int n = 0; n < 40; n++) begin
         access($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and memory is word-indexed.
REQ-002 The port list SHALL be:
- clk_i  in  1  single clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  pipeline memory request; held high while stall_o=1
- we_i  in  1  1=store, 0=load
- size_i  in  2  00=byte, 01=half, 10=word, 11=reserved
- sign_ext_i  in  1  load sign-extend enable (byte/half)
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- stall_o  out  1  pipeline hold request
- done_o  out  1  one-cycle completion pulse
- misaligned_o  out  1  qualifies done_o; access rejected
- rdata_o  out  32  aligned, extended load result
- mem_read_o  out  1  data-memory read strobe
- mem_write_o  out  1  data-memory write strobe
- mem_addr_o  out  32  data-memory word index
- mem_wdata_o  out  32  data-memory write word
- mem_rdata_i  in  32  data-memory registered read data

Function
REQ-003 The FSM SHALL have states IDLE, READ, WAIT, WRITE, DONE, with Moore-decoded memory strobes.
REQ-004 In IDLE with req_i=1, the block SHALL capture addr, size, we, wdata and sign_ext; req_i SHALL be ignored in every other state.
REQ-005 A misaligned access SHALL go from IDLE to DONE with misaligned_o=1 and no memory strobe; misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-006 Loads SHALL follow IDLE->READ->WAIT->DONE; done_o SHALL assert 3 cycles after acceptance.
REQ-007 Word stores SHALL follow IDLE->WRITE->DONE; done_o SHALL assert 2 cycles after acceptance.
REQ-008 Byte and half stores SHALL use read-modify-write, IDLE->READ->WAIT->WRITE->DONE; done_o SHALL assert 4 cycles after acceptance.
REQ-009 The memory strobes SHALL assert only as follows:
- mem_read_o=1 only in READ
- mem_write_o=1 only in WRITE
- mem_addr_o={2'b00, addr[31:2]} in READ and WRITE, 0 otherwise
REQ-010 In WAIT, the block SHALL sample mem_rdata_i (valid one cycle after the READ strobe).
- Load: rdata_o SHALL be registered with the extracted lane.
- Store: the merged word SHALL be registered for WRITE.
REQ-011 Lane selection SHALL be little-endian:
- byte k = bits [8k+7:8k], k=addr[1:0]
- half h = bits [16h+15:16h], h=addr[1]
REQ-012 Loads SHALL zero-extend when sign_ext_i=0 and replicate the lane MSB when sign_ext_i=1; word loads SHALL pass through unchanged.
REQ-013 Store merge SHALL replace only the addressed lane with wdata[7:0] or wdata[15:0]; all other bytes SHALL be preserved.
REQ-014 stall_o SHALL equal (state==IDLE && req_i) || state is READ, WAIT or WRITE; it SHALL be 0 in DONE.
REQ-015 done_o SHALL be 1 only in DONE; misaligned_o SHALL be 0 outside DONE.
REQ-016 rdata_o SHALL hold its value until the next successful load completes; stores and misaligned accesses SHALL leave it unchanged.
REQ-017 DONE SHALL always return to IDLE; a back-to-back request SHALL be accepted in the following IDLE cycle.

Reset
REQ-018 rst_i=1 SHALL immediately force the following, independent of clk_i:
- state=IDLE
- rdata_o, captured registers, merged word = 0
- done_o, misaligned_o, mem_read_o, mem_write_o = 0
- mem_addr_o, mem_wdata_o = 0
REQ-019 Reset asserted mid-operation SHALL abandon the access; a WRITE in progress SHALL drop mem_write_o before the next edge, leaving memory unchanged.

Structure
REQ-020 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-021 Lane extraction, extension and merge SHALL reside in one combinational sub-module, mem_lane_align; the FSM and registers SHALL stay in mem_access_ctrl.

Verification
REQ-022 The bench SHALL model the data memory with registered read data and preload word 3 = 0x8899AABB.
- lw 0x0C: mem_read_o with mem_addr_o=3 one cycle after acceptance; done_o at cycle 3; rdata_o=0x8899AABB.
- lb 0x0D, sign_ext=1 -> rdata_o=0xFFFFFFAA; lbu 0x0D -> 0x000000AA; lh 0x0E, sign_ext=1 -> 0xFFFF8899.
- sb 0x0E, wdata=0x12345677: mem_write_o with mem_wdata_o=0x8877AABB; done_o at cycle 4; rdata_o unchanged.
- sh 0x0F: done_o and misaligned_o at cycle 1; no strobes; stall_o=1 only in the accept cycle.
- sw 0x10, wdata=0xDEADBEEF, then lw 0x10 back-to-back: write at index 4 with done_o at cycle 2; load returns 0xDEADBEEF.
- rst_i pulsed while in WRITE: mem_write_o=0 immediately; word unchanged; stall_o=0; next request behaves normally.
